bus_a8_responder: RTL and testbench
===================================

BUS_A8_RESPONDER -- requirements
Module: bus_a8_responder

Interface
REQ-001 TICK_BITS, 7, width of the in-cycle tick counter; it counts clk200 periods since the synchronised a8_clk falling edge.
REQ-002 TICK_DECIDE, 34, tick at which a8_extsel_n and a8_rw_n are sampled to claim the cycle.
REQ-003 TICK_WRITE_VALID, 82, tick at which A8 write data is captured.
REQ-004 TICK_READ_DEADLINE, 90, last tick by which read data must be on the bus.
REQ-005 HOLD_TICKS, 4, clk200 periods a8_data_oe stays high after the detected falling edge.
REQ-006 clk200  in  1  FPGA clock, 200 MHz; the only clock.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 a8_clk  in  1  A8 phi2, asynchronous to clk200.
REQ-009 a8_rw_n  in  1  A8 read/write; 1 = read.
REQ-010 a8_addr  in  16  A8 address bus.
REQ-011 a8_data_in  in  8  A8 data bus, input side.
REQ-012 a8_extsel_n  in  1  page-claim decision from the bus monitor; 0 = FPGA sources the page.
REQ-013 a8_data_out  out  8  data driven onto the A8 bus.
REQ-014 a8_data_oe  out  1  data-bus output enable.
REQ-015 mem_req  out  1  memory-side request, level.
REQ-016 mem_we  out  1  1 = write request.
REQ-017 mem_addr  out  16  latched A8 address.
REQ-018 mem_wdata  out  8  latched write data.
REQ-019 mem_ack  in  1  one-cycle acknowledge from the memory side.
REQ-020 mem_rdata  in  8  read data; valid only in the mem_ack cycle.
REQ-021 rd_timeout  out  1  one-cycle pulse when a read misses TICK_READ_DEADLINE.
REQ-022 wr_drop  out  1  one-cycle pulse when a claimed cycle is lost because a write request is still pending.

Function
REQ-023 a8_clk SHALL be synchronised through a 3-flop shift register; the falling edge is detected when bits [2:1] equal 10.
REQ-024 ticks SHALL clear on the detected falling edge, otherwise increment, and saturate at all-ones so decision ticks never retrigger while a8_clk is stopped.
REQ-025 The FSM SHALL have the states IDLE, RD_REQ, DRIVE, HOLD, WR_WAIT and WR_REQ.
REQ-026 IDLE, at ticks==TICK_DECIDE with a8_extsel_n=0: latch a8_addr into mem_addr; go to RD_REQ if a8_rw_n=1, otherwise to WR_WAIT; if a8_extsel_n=1, stay in IDLE.
REQ-027 RD_REQ: mem_req=1 and mem_we=0 from the entry cycle. On mem_ack, register mem_rdata into a8_data_out, set a8_data_oe=1, drop mem_req, and go to DRIVE.
REQ-028 RD_REQ, at ticks==TICK_READ_DEADLINE without mem_ack: a8_data_out=8'hFF, a8_data_oe=1, pulse rd_timeout, drop mem_req, and go to DRIVE.
REQ-029 RD_REQ: if mem_ack and the deadline occur in the same cycle, mem_ack wins and rd_timeout stays 0.
REQ-030 mem_ack received outside RD_REQ and WR_REQ SHALL be ignored; this includes a late ack for an abandoned read.
REQ-031 DRIVE: a8_data_oe stays 1 until the detected falling edge, then go to HOLD.
REQ-032 HOLD: after HOLD_TICKS cycles, a8_data_oe=0 and return to IDLE.
REQ-033 WR_WAIT: at ticks==TICK_WRITE_VALID, capture a8_data_in into mem_wdata and go to WR_REQ.
REQ-034 WR_REQ: mem_req=1 and mem_we=1 until mem_ack, then go to IDLE. WR_REQ may span into the next A8 cycle.
REQ-035 If ticks==TICK_DECIDE occurs in WR_REQ with a8_extsel_n=0, pulse wr_drop and do not claim that cycle.
REQ-036 A falling edge detected in WR_WAIT (a short cycle) SHALL return the FSM to IDLE without a request.
REQ-037 mem_addr and mem_wdata SHALL be stable while mem_req=1.
REQ-038 a8_data_oe SHALL never be 1 while a8_rw_n=0 is sampled in a claimed cycle.

Reset
REQ-039 When rst=1 at a clk200 edge, the block SHALL set: FSM=IDLE, ticks=0, sync flops=0, a8_data_oe=0, a8_data_out=8'h00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_timeout=0, wr_drop=0.
REQ-040 A reset asserted mid-request SHALL abandon the request immediately, with no further ack handling.

Configuration
REQ-041 With BUS_A8_RESP_WRITE_EN defined: the write path operates as specified in REQ-033 to REQ-036.
REQ-042 Without BUS_A8_RESP_WRITE_EN: claimed write cycles stay in IDLE, mem_we is tied 0, mem_wdata is tied 0, and wr_drop is tied 0.

Verification
REQ-043 Read hit: extsel_n=0, rw_n=1, addr=16'hD612, ack at tick 50 with rdata=8'h5A -> data_out=8'h5A, oe=1 from tick 51 until falling edge plus 4 ticks.
REQ-044 Read timeout: no ack -> at tick 90 data_out=8'hFF, oe=1, one rd_timeout pulse; an ack at tick 95 is ignored.
REQ-045 Write: rw_n=0, data=8'hC3 at tick 82 -> mem_req=1, mem_we=1, mem_wdata=8'hC3, mem_addr latched; req drops the cycle after ack.
REQ-046 Write ack delayed by 120 ticks with next cycle claimed -> wr_drop pulses at tick 34; the second cycle is not serviced.
REQ-047 Unclaimed cycle (extsel_n=1) -> mem_req=0 and oe=0 throughout; a8_clk held high for 300 ticks -> ticks saturates at 127 and no request is made.
REQ-048 rst=1 during RD_REQ -> all outputs at reset values on the next edge; mem_req=0.

Source files
------------

// File: rtl/bus_a8_responder.sv
// bus_a8_responder: serves claimed A8 bus cycles from a memory-side port.
// Optional write path enabled by defining BUS_A8_RESP_WRITE_EN.
`timescale 1ns/1ps
module bus_a8_responder #(
  parameter int TICK_BITS          = 7,
  parameter int TICK_DECIDE        = 34,
  parameter int TICK_WRITE_VALID   = 82,
  parameter int TICK_READ_DEADLINE = 90,
  parameter int HOLD_TICKS         = 4
) (
  input  logic        clk200,
  input  logic        rst,
  input  logic        a8_clk,
  input  logic        a8_rw_n,
  input  logic [15:0] a8_addr,
  input  logic [7:0]  a8_data_in,
  input  logic        a8_extsel_n,
  output logic [7:0]  a8_data_out,
  output logic        a8_data_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        rd_timeout,
  output logic        wr_drop
);

  localparam int HOLD_W =
    (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    DRIVE,
    HOLD,
    WR_WAIT,
    WR_REQ
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           sync_q, sync_d;
  logic [TICK_BITS-1:0] ticks_q, ticks_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [7:0]           dout_q, dout_d;
  logic                 oe_q, oe_d;
  logic                 req_q, req_d;
  logic [15:0]          addr_q, addr_d;
  logic                 rd_to_q, rd_to_d;
`ifdef BUS_A8_RESP_WRITE_EN
  logic                 we_q, we_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 drop_q, drop_d;
`endif

  logic fall;
  logic claim;
  logic at_decide;
  logic at_wvalid;
  logic at_deadline;

  // bit 2 is the oldest sample of a8_clk
  assign fall        = sync_q[2] & ~sync_q[1];
  assign at_decide   = ticks_q == TICK_BITS'(TICK_DECIDE);
  assign at_wvalid   = ticks_q == TICK_BITS'(TICK_WRITE_VALID);
  assign at_deadline = ticks_q == TICK_BITS'(TICK_READ_DEADLINE);
  assign claim       = at_decide & ~a8_extsel_n;

  always_comb begin
    sync_d  = {sync_q[1:0], a8_clk};
    ticks_d = ticks_q;
    if (fall) begin
      ticks_d = '0;
    end else if (ticks_q != '1) begin
      ticks_d = ticks_q + 1'b1;
    end
    state_d = state_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    req_d   = req_q;
    addr_d  = addr_q;
    rd_to_d = 1'b0;
`ifdef BUS_A8_RESP_WRITE_EN
    we_d    = we_q;
    wdata_d = wdata_q;
    drop_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (claim) begin
          addr_d = a8_addr;
          if (a8_rw_n) begin
            state_d = RD_REQ;
            req_d   = 1'b1;
          end
`ifdef BUS_A8_RESP_WRITE_EN
          else begin
            state_d = WR_WAIT;
          end
`endif
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          dout_d  = mem_rdata;
          oe_d    = 1'b1;
          req_d   = 1'b0;
          state_d = DRIVE;
        end else if (at_deadline) begin
          dout_d  = 8'hFF;
          oe_d    = 1'b1;
          rd_to_d = 1'b1;
          req_d   = 1'b0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (fall) begin
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
`ifdef BUS_A8_RESP_WRITE_EN
      WR_WAIT: begin
        if (fall) begin
          state_d = IDLE;
        end else if (at_wvalid) begin
          wdata_d = a8_data_in;
          req_d   = 1'b1;
          we_d    = 1'b1;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        // a cycle claimed while the write is still pending is lost
        if (claim) begin
          drop_d = 1'b1;
        end
        if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = IDLE;
        end
      end
`else
      WR_WAIT, WR_REQ: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk200) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      ticks_q <= '0;
      hold_q  <= '0;
      dout_q  <= 8'h00;
      oe_q    <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      rd_to_q <= 1'b0;
`ifdef BUS_A8_RESP_WRITE_EN
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      drop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ticks_q <= ticks_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rd_to_q <= rd_to_d;
`ifdef BUS_A8_RESP_WRITE_EN
      we_q    <= we_d;
      wdata_q <= wdata_d;
      drop_q  <= drop_d;
`endif
    end
  end

  assign a8_data_out = dout_q;
  assign a8_data_oe  = oe_q;
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign rd_timeout  = rd_to_q;

`ifdef BUS_A8_RESP_WRITE_EN
  assign mem_we      = we_q;
  assign mem_wdata   = wdata_q;
  assign wr_drop     = drop_q;
`else
  logic unused_wr;
  assign unused_wr   = ^{a8_data_in, at_wvalid};
  assign mem_we      = 1'b0;
  assign mem_wdata   = 8'h00;
  assign wr_drop     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_a8_responder.sv
// Directed bench for bus_a8_responder: reads, timeout, writes, stall, reset.
// Write-path checks follow BUS_A8_RESP_WRITE_EN.
`timescale 1ns/1ps
module tb_bus_a8_responder;

  logic        clk200;
  logic        rst;
  logic        a8_clk;
  logic        a8_rw_n;
  logic [15:0] a8_addr;
  logic [7:0]  a8_data_in;
  logic        a8_extsel_n;
  logic [7:0]  a8_data_out;
  logic        a8_data_oe;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        rd_timeout;
  logic        wr_drop;

  int n_vec = 0;
  int n_err = 0;
  int tk    = 0;

  bus_a8_responder dut (
    .clk200      (clk200),
    .rst         (rst),
    .a8_clk      (a8_clk),
    .a8_rw_n     (a8_rw_n),
    .a8_addr     (a8_addr),
    .a8_data_in  (a8_data_in),
    .a8_extsel_n (a8_extsel_n),
    .a8_data_out (a8_data_out),
    .a8_data_oe  (a8_data_oe),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .rd_timeout  (rd_timeout),
    .wr_drop     (wr_drop)
  );

  initial clk200 = 1'b0;
  always #2.5 clk200 = ~clk200;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // one clk200 period; tk mirrors the expected tick count
  task automatic cyc();
    @(posedge clk200);
    if (rst) tk = 0;
    else if (tk != 127) tk++;
    @(negedge clk200);
  endtask

  task automatic goto_tick(input int n);
    int g;
    g = 0;
    while (tk != n && g < 200) begin
      cyc();
      g++;
    end
    if (tk != n) begin
      n_err++;
      $display("FAIL goto_tick observed=%0d expected=%0d",
               tk, n);
    end
  endtask

  // a8_clk high, then low; returns in the tick-0 period
  task automatic new_cycle();
    a8_clk = 1'b1;
    repeat (3) cyc();
    a8_clk = 1'b0;
    cyc();
    cyc();
    @(posedge clk200);
    tk = 0;
    @(negedge clk200);
  endtask

  logic seen;

  initial begin
    rst         = 1'b1;
    a8_clk      = 1'b0;
    a8_rw_n     = 1'b1;
    a8_addr     = 16'hAAAA;
    a8_data_in  = 8'h55;
    a8_extsel_n = 1'b0;
    mem_ack     = 1'b1;
    mem_rdata   = 8'hEE;
    seen        = 1'b0;
    @(negedge clk200);
    repeat (3) cyc();

    chk("rst_oe", a8_data_oe, 1'b0);
    chk("rst_dout", a8_data_out, 8'h00);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_rdto", rd_timeout, 1'b0);
    chk("rst_drop", wr_drop, 1'b0);

    a8_extsel_n = 1'b1;
    mem_ack     = 1'b0;
    mem_rdata   = 8'h00;
    rst         = 1'b0;
    goto_tick(110);
    new_cycle();

    // read hit
    a8_addr     = 16'hD612;
    a8_rw_n     = 1'b1;
    a8_extsel_n = 1'b0;
    goto_tick(34);
    chk("hit_req_pre", mem_req, 1'b0);
    goto_tick(35);
    chk("hit_req", mem_req, 1'b1);
    chk("hit_we", mem_we, 1'b0);
    chk("hit_addr", mem_addr, 16'hD612);
    a8_addr     = 16'h0000;
    a8_extsel_n = 1'b1;
    goto_tick(50);
    mem_ack   = 1'b1;
    mem_rdata = 8'h5A;
    chk("hit_oe_t50", a8_data_oe, 1'b0);
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    chk("hit_dout", a8_data_out, 8'h5A);
    chk("hit_oe_t51", a8_data_oe, 1'b1);
    chk("hit_req_drop", mem_req, 1'b0);
    chk("hit_addr_hold", mem_addr, 16'hD612);
    goto_tick(100);
    chk("hit_oe_t100", a8_data_oe, 1'b1);
    new_cycle();
    chk("hold_t0", a8_data_oe, 1'b1);
    goto_tick(3);
    chk("hold_t3", a8_data_oe, 1'b1);
    goto_tick(4);
    chk("hold_t4", a8_data_oe, 1'b0);

    // read timeout, late ack ignored
    a8_addr     = 16'h1234;
    a8_extsel_n = 1'b0;
    goto_tick(35);
    chk("to_req", mem_req, 1'b1);
    a8_extsel_n = 1'b1;
    goto_tick(90);
    chk("to_pre_pulse", rd_timeout, 1'b0);
    chk("to_pre_oe", a8_data_oe, 1'b0);
    cyc();
    chk("to_dout", a8_data_out, 8'hFF);
    chk("to_oe", a8_data_oe, 1'b1);
    chk("to_pulse", rd_timeout, 1'b1);
    chk("to_req_drop", mem_req, 1'b0);
    cyc();
    chk("to_pulse_end", rd_timeout, 1'b0);
    goto_tick(95);
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    chk("late_ack_dout", a8_data_out, 8'hFF);
    chk("late_ack_req", mem_req, 1'b0);
    goto_tick(110);
    new_cycle();

    // ack on the deadline tick wins
    a8_addr     = 16'h4321;
    a8_extsel_n = 1'b0;
    goto_tick(35);
    a8_extsel_n = 1'b1;
    goto_tick(90);
    mem_ack   = 1'b1;
    mem_rdata = 8'h3C;
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    chk("tie_dout", a8_data_out, 8'h3C);
    chk("tie_pulse", rd_timeout, 1'b0);
    chk("tie_oe", a8_data_oe, 1'b1);
    goto_tick(110);
    new_cycle();
    goto_tick(10);

    // claimed write cycle
    a8_addr     = 16'hBEEF;
    a8_rw_n     = 1'b0;
    a8_data_in  = 8'hC3;
    a8_extsel_n = 1'b0;
    goto_tick(35);
    a8_extsel_n = 1'b1;
    chk("wr_drop_t35", wr_drop, 1'b0);
`ifdef BUS_A8_RESP_WRITE_EN
    goto_tick(82);
    chk("wr_req_pre", mem_req, 1'b0);
    cyc();
    chk("wr_req", mem_req, 1'b1);
    chk("wr_we", mem_we, 1'b1);
    chk("wr_wdata", mem_wdata, 8'hC3);
    chk("wr_addr", mem_addr, 16'hBEEF);
    chk("wr_oe", a8_data_oe, 1'b0);
    a8_data_in = 8'h00;
    a8_addr    = 16'h0000;
    goto_tick(90);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("wr_req_drop", mem_req, 1'b0);
    chk("wr_we_drop", mem_we, 1'b0);
    goto_tick(110);
    new_cycle();

    // slow write ack collides with the next claim
    a8_addr     = 16'h0F0F;
    a8_data_in  = 8'h81;
    a8_extsel_n = 1'b0;
    goto_tick(35);
    a8_extsel_n = 1'b1;
    goto_tick(83);
    chk("wr2_req", mem_req, 1'b1);
    chk("wr2_wdata", mem_wdata, 8'h81);
    goto_tick(110);
    new_cycle();
    a8_addr     = 16'h2222;
    a8_rw_n     = 1'b1;
    a8_extsel_n = 1'b0;
    goto_tick(35);
    a8_extsel_n = 1'b1;
    chk("drop_pulse", wr_drop, 1'b1);
    chk("drop_we", mem_we, 1'b1);
    chk("drop_addr", mem_addr, 16'h0F0F);
    chk("drop_wdata", mem_wdata, 8'h81);
    cyc();
    chk("drop_pulse_end", wr_drop, 1'b0);
    goto_tick(87);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("drop_req_end", mem_req, 1'b0);
    goto_tick(100);
    chk("drop_no_rd_req", mem_req, 1'b0);
    chk("drop_no_oe", a8_data_oe, 1'b0);
`else
    goto_tick(83);
    chk("wr_off_req", mem_req, 1'b0);
    chk("wr_off_we", mem_we, 1'b0);
    chk("wr_off_wdata", mem_wdata, 8'h00);
    chk("wr_off_oe", a8_data_oe, 1'b0);
    goto_tick(100);
    chk("wr_off_req_t100", mem_req, 1'b0);
`endif
    goto_tick(110);
    new_cycle();

    // unclaimed cycle, then a8_clk stalled high
    a8_addr     = 16'h5555;
    a8_rw_n     = 1'b1;
    a8_extsel_n = 1'b1;
    goto_tick(35);
    chk("uncl_req", mem_req, 1'b0);
    chk("uncl_oe", a8_data_oe, 1'b0);
    goto_tick(60);
    a8_clk      = 1'b1;
    a8_extsel_n = 1'b0;
    seen        = 1'b0;
    repeat (300) begin
      cyc();
      seen = seen | mem_req | a8_data_oe;
    end
    chk("stall_no_req", seen, 1'b0);
    a8_extsel_n = 1'b1;
    new_cycle();

    // reset in the middle of a read request
    a8_addr     = 16'h9A9A;
    a8_extsel_n = 1'b0;
    goto_tick(35);
    chk("mid_req", mem_req, 1'b1);
    chk("mid_dout_pre", a8_data_out, 8'h3C);
    a8_extsel_n = 1'b1;
    goto_tick(40);
    rst = 1'b1;
    cyc();
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_addr", mem_addr, 16'h0000);
    chk("mid_rst_dout", a8_data_out, 8'h00);
    chk("mid_rst_oe", a8_data_oe, 1'b0);
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h99;
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    cyc();
    chk("post_rst_dout", a8_data_out, 8'h00);
    chk("post_rst_oe", a8_data_oe, 1'b0);
    chk("post_rst_req", mem_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
